led_matrix_scanner: RTL

LED_MATRIX_SCANNER -- requirements
Module: led_matrix_scanner

---
 rtl/led_matrix_pkg.sv | 23 ++
 rtl/led_matrix_scanner_if.sv | 18 +
 rtl/led_matrix_framebuf.sv | 44 ++++
 rtl/led_matrix_scanner.sv | 99 +++++++++
 4 files changed

// File: rtl/led_matrix_pkg.sv
// led_matrix_pkg: shared constants for the LED matrix scanner slice.
//   ROWS_DEF/COLS_DEF/DIV_DEF/BLANK_DEF : default geometry and timing.
//   idx_w()                             : counter width for an index range 0..n-1.
//   ROW_W_DEF/SLOT_W_DEF                : row-index and slot-index widths for the defaults.
package led_matrix_pkg;

    localparam int ROWS_DEF  = 8;
    localparam int COLS_DEF  = 8;
    localparam int DIV_DEF   = 256;
    localparam int BLANK_DEF = 4;

    // Brightness steps; the PWM limit divides the active window by this.
    localparam int PWM_LEVELS = 16;

    // Width of a counter spanning 0..n-1, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ROW_W_DEF  = idx_w(ROWS_DEF);
    localparam int SLOT_W_DEF = idx_w(DIV_DEF);

endpackage

// File: rtl/led_matrix_scanner_if.sv
// led_matrix_scanner_if: frame load handshake.
//   frame_in    : ROWS*COLS frame, bit r*COLS+c is row r, column c
//   frame_valid : frame_in is valid
//   frame_ready : a frame can be accepted
// master drives frames in, slave (the scanner) accepts them.
interface led_matrix_scanner_if
    import led_matrix_pkg::*;
#(
    parameter int ROWS = ROWS_DEF,
    parameter int COLS = COLS_DEF
);
    logic [ROWS*COLS-1:0] frame_in;
    logic                 frame_valid;
    logic                 frame_ready;

    modport master (output frame_in, output frame_valid, input  frame_ready);
    modport slave  (input  frame_in, input  frame_valid, output frame_ready);
endinterface

// File: rtl/led_matrix_framebuf.sv
// led_matrix_framebuf: shadow/display double buffer for the scanner.
//   clk, _rst    : clock, async active-low reset (clears both buffers and pending)
//   frame_in     : incoming frame, captured into shadow on valid && ready
//   frame_valid  : frame_in is valid
//   frame_ready  : high while no frame is pending
//   swap         : scan boundary; a pending frame moves shadow -> display here
//   display      : rows currently being scanned out
module led_matrix_framebuf
    import led_matrix_pkg::*;
#(
    parameter int ROWS = ROWS_DEF,
    parameter int COLS = COLS_DEF
) (
    input  logic                       clk,
    input  logic                       _rst,
    input  logic [ROWS*COLS-1:0]       frame_in,
    input  logic                       frame_valid,
    output logic                       frame_ready,
    input  logic                       swap,
    output logic [ROWS-1:0][COLS-1:0]  display
);

    logic                      pending;
    logic [ROWS-1:0][COLS-1:0] shadow;

    assign frame_ready = ~pending;

    // Accept and swap are exclusive: accept needs pending low, swap acts only
    // with pending high, so one edge never does both.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            pending <= 1'b0;
            shadow  <= '0;
            display <= '0;
        end else if (frame_valid && !pending) begin
            shadow  <= frame_in;
            pending <= 1'b1;
        end else if (swap && pending) begin
            display <= shadow;
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: row-multiplexed LED matrix driver with double-buffered frames.
//   clk, _rst   : clock, async active-low reset
//   frm         : frame load handshake (slave side)
//   brightness  : 4-bit PWM level, only when LED_MATRIX_PWM_EN is defined
//   row_out     : one-hot row drive, all-zero during the blank window
//   col_out     : column data of the driven row
//   frame_tick  : one-cycle pulse with the last active output of the last row
// Each row slot lasts DIV clocks; the first BLANK clocks are dark to stop ghosting.
// All outputs are registered and lag the counters by one clock.
// Optional feature macro: LED_MATRIX_PWM_EN (brightness gating of col_out).
module led_matrix_scanner
    import led_matrix_pkg::*;
#(
    parameter int ROWS  = ROWS_DEF,
    parameter int COLS  = COLS_DEF,
    parameter int DIV   = DIV_DEF,
    parameter int BLANK = BLANK_DEF
) (
    input  logic              clk,
    input  logic              _rst,
    led_matrix_scanner_if.slave frm,
`ifdef LED_MATRIX_PWM_EN
    input  logic [3:0]        brightness,
`endif
    output logic [ROWS-1:0]   row_out,
    output logic [COLS-1:0]   col_out,
    output logic              frame_tick
);

    localparam int ROW_W  = idx_w(ROWS);
    localparam int SLOT_W = idx_w(DIV);

    logic [ROW_W-1:0]          row;
    logic [SLOT_W-1:0]         slot;
    logic                      last_slot, boundary, active, col_en;
    logic [ROWS-1:0][COLS-1:0] display;

    assign last_slot = (slot == SLOT_W'(DIV - 1));
    assign boundary  = last_slot && (row == ROW_W'(ROWS - 1));
    assign active    = (slot >= SLOT_W'(BLANK));

    led_matrix_framebuf #(.ROWS(ROWS), .COLS(COLS)) u_fb (
        .clk         (clk),
        ._rst        (_rst),
        .frame_in    (frm.frame_in),
        .frame_valid (frm.frame_valid),
        .frame_ready (frm.frame_ready),
        .swap        (boundary),
        .display     (display)
    );

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            slot <= '0;
            row  <= '0;
        end else if (last_slot) begin
            slot <= '0;
            row  <= (row == ROW_W'(ROWS - 1)) ? '0 : row + ROW_W'(1);
        end else begin
            slot <= slot + SLOT_W'(1);
        end
    end

`ifdef LED_MATRIX_PWM_EN
    // Wide enough for (15+1)*(DIV-BLANK) without overflow.
    localparam int PW = SLOT_W + 5;

    logic [3:0]    bright_q;
    logic [PW-1:0] on_limit, act_idx;

    // Brightness only moves at scan boundaries so a frame never mixes levels.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst)         bright_q <= 4'd15;
        else if (boundary) bright_q <= brightness;
    end

    // act_idx wraps below BLANK, but active masks those slots anyway.
    always_comb begin
        on_limit = ((PW'(bright_q) + PW'(1)) * PW'(DIV - BLANK)) / PW'(PWM_LEVELS);
        act_idx  = PW'(slot) - PW'(BLANK);
        col_en   = (act_idx < on_limit);
    end
`else
    assign col_en = 1'b1;
`endif

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            row_out    <= '0;
            col_out    <= '0;
            frame_tick <= 1'b0;
        end else begin
            row_out    <= active ? (ROWS'(1) << row) : '0;
            col_out    <= (active && col_en) ? display[row] : '0;
            frame_tick <= boundary;
        end
    end

endmodule
